// File: rtl/tqvp_crc_pkg.sv
// Shared definitions for the TinyQV CRC engine: register map, bit indices,
// engine state encoding and a byte bit-reversal helper.
package tqvp_crc_pkg;

    // Register addresses
    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_DATA  = 4'h1;
    localparam logic [3:0] ADDR_RES0  = 4'h2;
    localparam logic [3:0] ADDR_RES3  = 4'h5;
    localparam logic [3:0] ADDR_POLY0 = 4'h6;
    localparam logic [3:0] ADDR_POLY3 = 4'h9;
    localparam logic [3:0] ADDR_INIT0 = 4'hA;
    localparam logic [3:0] ADDR_INIT3 = 4'hD;
    localparam logic [3:0] ADDR_STAT  = 4'hE;

    // CTRL bit indices
    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_REFIN  = 1;
    localparam int CTRL_REFOUT = 2;
    localparam int CTRL_INV    = 3;

    // STAT bit indices (read view); OVF_CLR is the write-one-to-clear bit
    localparam int STAT_BUSY    = 7;
    localparam int STAT_OVF     = 6;
    localparam int STAT_FULL    = 5;
    localparam int STAT_EMPTY   = 4;
    localparam int STAT_OVF_CLR = 6;

    // Serial engine state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

    // Reverse the bit order of a byte
    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/tqvp_byte_fifo.sv
// Small byte FIFO feeding the CRC engine. A synchronous flush empties it.
//
// Handshake: push is accepted in a cycle when the FIFO is not full, or when a
// pop is accepted in that same cycle (the pop frees the slot). pop is honoured
// only when the FIFO is not empty; dout always shows the head entry.
module tqvp_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tqvp_crc_engine.sv
// Runtime-programmable CRC engine for TinyQV. Bytes written to DATA are
// buffered in a small FIFO and fed bit-serially into an MSB-first CRC
// register, BITS_PER_CYCLE bits per clock.
module tqvp_crc_engine
    import tqvp_crc_pkg::*;
#(
    parameter int          WIDTH          = 32,
    parameter logic [31:0] POLY           = 32'h04C11DB7,
    parameter logic [31:0] INIT           = 32'hFFFFFFFF,
    parameter bit          REFIN          = 1'b1,
    parameter bit          REFOUT         = 1'b1,
    parameter bit          XOR_INV        = 1'b1,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int         LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int         STEPS    = 8 / BITS_PER_CYCLE;
    localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

    // Programmable state
    logic [WIDTH-1:0] poly_q;
    logic [WIDTH-1:0] init_q;
    logic             refin_q;
    logic             refout_q;
    logic             inv_q;
    logic             overflow_q;

    // Engine state; state_q is the FSM state visible to checkers
    crc_state_e       state_q;
    logic [2:0]       cnt_q;
    logic [7:0]       shreg_q;
    logic [WIDTH-1:0] crc_q;

    // FIFO interface
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    // Decoded register accesses
    logic       wr_ctrl, wr_data, wr_stat, wr_poly, wr_init, clear;
    logic [1:0] lane;
    logic       busy;

    logic             unused_ok;
    assign unused_ok = &{1'b0, ui_in};

    assign wr_ctrl = data_write && (address == ADDR_CTRL);
    assign wr_data = data_write && (address == ADDR_DATA);
    assign wr_stat = data_write && (address == ADDR_STAT);
    assign wr_poly = data_write && (address inside {[ADDR_POLY0:ADDR_POLY3]});
    assign wr_init = data_write && (address inside {[ADDR_INIT0:ADDR_INIT3]});
    assign clear   = wr_ctrl && data_in[CTRL_CLEAR];
    // RESULT, POLY and INIT groups all start at an address with low bits 2'b10
    assign lane    = address[1:0] - ADDR_POLY0[1:0];

    assign busy = (state_q != ST_IDLE) || !fifo_empty;

    // Pop when idle, or on the final clock of a byte so bytes run back to back
    assign fifo_pop = !clear && !fifo_empty &&
                      ((state_q == ST_IDLE) || (cnt_q == LAST_CNT));

    tqvp_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (wr_data),
        .din   (data_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Replace one byte lane of a WIDTH-bit register; bits above WIDTH drop off
    function automatic logic [WIDTH-1:0] set_lane(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0] ln,
                                                  input logic [7:0] b);
        logic [31:0] w;
        w = 32'(cur);
        w[{ln, 3'b000} +: 8] = b;
        return w[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] reflect_w(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // BITS_PER_CYCLE CRC steps; the shift register always presents the next bit at [0]
    logic [WIDTH-1:0] crc_next;
    logic [7:0]       sh_next;
    always_comb begin
        logic [WIDTH-1:0] c;
        logic [7:0]       s;
        logic             fb;
        c = crc_q;
        s = shreg_q;
        fb = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            fb = c[WIDTH-1] ^ s[0];
            c  = {c[WIDTH-2:0], 1'b0} ^ (fb ? poly_q : '0);
            s  = {1'b0, s[7:1]};
        end
        crc_next = c;
        sh_next  = s;
    end

    // refin=1 feeds bit0 first, so the byte loads as-is; otherwise reversed
    logic [7:0] load_byte;
    assign load_byte = refin_q ? fifo_dout : reflect8(fifo_dout);

    // Serial engine FSM: pop, shift 8/BPC clocks, chain to the next byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            crc_q   <= INIT[WIDTH-1:0];
        end else if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            crc_q   <= init_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shreg_q <= load_byte;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_q   <= crc_next;
                    shreg_q <= sh_next;
                    if (cnt_q == LAST_CNT) begin
                        if (fifo_pop) begin
                            shreg_q <= load_byte;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Software-visible configuration and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poly_q     <= POLY[WIDTH-1:0];
            init_q     <= INIT[WIDTH-1:0];
            refin_q    <= REFIN;
            refout_q   <= REFOUT;
            inv_q      <= XOR_INV;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                refin_q  <= data_in[CTRL_REFIN];
                refout_q <= data_in[CTRL_REFOUT];
                inv_q    <= data_in[CTRL_INV];
            end
            if (wr_poly) poly_q <= set_lane(poly_q, lane, data_in);
            if (wr_init) init_q <= set_lane(init_q, lane, data_in);
            // A push into a full FIFO with no pop in the same clock is dropped
            if (wr_data && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            else if (wr_stat && data_in[STAT_OVF_CLR]) overflow_q <= 1'b0;
        end
    end

    logic [WIDTH-1:0] res_w;
    logic [31:0]      res32, poly32, init32;
    logic [3:0]       lvl4;
    assign res_w  = (refout_q ? reflect_w(crc_q) : crc_q) ^ {WIDTH{inv_q}};
    assign res32  = 32'(res_w);
    assign poly32 = 32'(poly_q);
    assign init32 = 32'(init_q);
    assign lvl4   = 4'(fifo_level);

    // Combinational register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL: data_out = {4'b0000, inv_q, refout_q, refin_q, 1'b0};
            ADDR_STAT: begin
                data_out[STAT_BUSY]  = busy;
                data_out[STAT_OVF]   = overflow_q;
                data_out[STAT_FULL]  = fifo_full;
                data_out[STAT_EMPTY] = fifo_empty;
                data_out[3:0]        = lvl4;
            end
            default: begin
                if (address inside {[ADDR_RES0:ADDR_RES3]})
                    data_out = res32[{lane, 3'b000} +: 8];
                else if (address inside {[ADDR_POLY0:ADDR_POLY3]})
                    data_out = poly32[{lane, 3'b000} +: 8];
                else if (address inside {[ADDR_INIT0:ADDR_INIT3]})
                    data_out = init32[{lane, 3'b000} +: 8];
            end
        endcase
    end

    assign uo_out = {6'b000000, overflow_q, busy};

endmodule

// File: tb/tb_tqvp_crc_engine.sv
// Bench for tqvp_crc_engine: default CRC-32 build, a CRC-16 (WIDTH=16) build
// and an 8-bits-per-clock build share one register bus.
module tb_tqvp_crc_engine;
    import tqvp_crc_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] ui_in;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] uo_out, uo_out16, uo_out8;
    logic [7:0] data_out, data_out16, data_out8;

    int n_checks = 0;
    int n_errors = 0;

    tqvp_crc_engine dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in),
        .data_out(data_out)
    );

    tqvp_crc_engine #(
        .WIDTH(16), .POLY(32'h00001021), .INIT(32'h0000FFFF),
        .REFIN(1'b0), .REFOUT(1'b0), .XOR_INV(1'b0)
    ) dut16 (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out16),
        .address(address), .data_write(data_write), .data_in(data_in),
        .data_out(data_out16)
    );

    tqvp_crc_engine #(.BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out8),
        .address(address), .data_write(data_write), .data_in(data_in),
        .data_out(data_out8)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- tables ----------------
    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp32;
        logic [7:0] exp16;
    } wr_vec_t;

    rd_vec_t rst_tab [16];
    wr_vec_t mask_tab [5];

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d,
                      output logic [7:0] d16, output logic [7:0] d8);
        @(negedge clk);
        address = a;
        #1;
        d   = data_out;
        d16 = data_out16;
        d8  = data_out8;
    endtask

    task automatic rd_res(output logic [31:0] r, output logic [31:0] r16,
                          output logic [31:0] r8);
        logic [7:0] b, b16, b8;
        r = '0; r16 = '0; r8 = '0;
        for (int i = 0; i < 4; i++) begin
            rd(4'(ADDR_RES0 + 4'(i)), b, b16, b8);
            r[i*8 +: 8]   = b;
            r16[i*8 +: 8] = b16;
            r8[i*8 +: 8]  = b8;
        end
    endtask

    // Paced pushes of "123456789": the slowest build drains each byte before the next
    task automatic push_check_string();
        for (int i = 0; i < 9; i++) begin
            wr(ADDR_DATA, 8'(8'h31 + i));
            repeat (8) @(negedge clk);
        end
    endtask

    // Back-to-back pushes, one per clock
    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            address    = ADDR_DATA;
            data_in    = 8'(8'h40 + i);
            data_write = 1'b1;
        end
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((uo_out[0] | uo_out16[0] | uo_out8[0]) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {29'b0, uo_out[0], uo_out16[0], uo_out8[0]}, 32'h0);
    endtask

    task automatic run_reset_table(input string tag);
        logic [7:0] d, d16, d8;
        for (int i = 0; i < 16; i++) begin
            rd(rst_tab[i].addr, d, d16, d8);
            chk($sformatf("%s_reg%0h", tag, rst_tab[i].addr), {24'b0, d}, {24'b0, rst_tab[i].exp});
        end
    endtask

    task automatic scenario_crc32(input string tag);
        logic [31:0] r, r16, r8;
        wr(ADDR_CTRL, 8'h0F);
        push_check_string();
        wait_idle({tag, "_drain"});
        rd_res(r, r16, r8);
        chk({tag, "_crc32"}, r, 32'hCBF43926);
        chk({tag, "_crc32_bpc8"}, r8, 32'hCBF43926);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r, r16, r8;
        logic [7:0]  d, d16, d8;
        int          c1, c8;

        rst_tab[0]  = '{ADDR_CTRL, 8'h0E};
        rst_tab[1]  = '{ADDR_DATA, 8'h00};
        rst_tab[2]  = '{4'h2, 8'h00};
        rst_tab[3]  = '{4'h3, 8'h00};
        rst_tab[4]  = '{4'h4, 8'h00};
        rst_tab[5]  = '{4'h5, 8'h00};
        rst_tab[6]  = '{4'h6, 8'hB7};
        rst_tab[7]  = '{4'h7, 8'h1D};
        rst_tab[8]  = '{4'h8, 8'hC1};
        rst_tab[9]  = '{4'h9, 8'h04};
        rst_tab[10] = '{4'hA, 8'hFF};
        rst_tab[11] = '{4'hB, 8'hFF};
        rst_tab[12] = '{4'hC, 8'hFF};
        rst_tab[13] = '{4'hD, 8'hFF};
        rst_tab[14] = '{ADDR_STAT, 8'h10};
        rst_tab[15] = '{4'hF, 8'h00};

        mask_tab[0] = '{4'h8, 8'h55, 8'h55, 8'h00};
        mask_tab[1] = '{4'hD, 8'hAA, 8'hAA, 8'h00};
        mask_tab[2] = '{4'hB, 8'h5A, 8'h5A, 8'h5A};
        mask_tab[3] = '{4'hF, 8'h12, 8'h00, 8'h00};
        mask_tab[4] = '{ADDR_CTRL, 8'h0E, 8'h0E, 8'h0E};

        // Reset
        rst        = 1'b1;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_uo_out", {24'b0, uo_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_reset_table("reset");

        // 1: CRC-32 check value, also on the 8-bit/clk build
        scenario_crc32("s1");

        // 2: reprogram to CRC-16/CCITT-FALSE
        wr(4'h6, 8'h21); wr(4'h7, 8'h10); wr(4'h8, 8'h00); wr(4'h9, 8'h00);
        wr(4'hA, 8'hFF); wr(4'hB, 8'hFF); wr(4'hC, 8'h00); wr(4'hD, 8'h00);
        wr(ADDR_CTRL, 8'h01);
        push_check_string();
        wait_idle("s2_drain");
        rd_res(r, r16, r8);
        chk("s2_crc16", r16, 32'h000029B1);

        // Register write/readback and masking above WIDTH
        for (int i = 0; i < 5; i++) begin
            wr(mask_tab[i].addr, mask_tab[i].wdata);
            rd(mask_tab[i].addr, d, d16, d8);
            chk($sformatf("mask32_%0h", mask_tab[i].addr), {24'b0, d}, {24'b0, mask_tab[i].exp32});
            chk($sformatf("mask16_%0h", mask_tab[i].addr), {24'b0, d16}, {24'b0, mask_tab[i].exp16});
        end

        // Restore CRC-32 defaults
        wr(4'h6, 8'hB7); wr(4'h7, 8'h1D); wr(4'h8, 8'hC1); wr(4'h9, 8'h04);
        wr(4'hA, 8'hFF); wr(4'hB, 8'hFF); wr(4'hC, 8'hFF); wr(4'hD, 8'hFF);
        wr(ADDR_CTRL, 8'h0F);

        // 4: latency of one byte, and BPC=1 vs BPC=8 agreement
        wr(ADDR_DATA, 8'h61);
        c1 = 0;
        c8 = 0;
        for (int i = 0; i < 30; i++) begin
            if (uo_out[0])  c1++;
            if (uo_out8[0]) c8++;
            @(negedge clk);
        end
        chk("s4_busy_bpc1", c1, 32'd9);
        chk("s4_busy_bpc8", c8, 32'd2);
        rd_res(r, r16, r8);
        chk("s4_crc_a_bpc1", r, 32'hE8B7BE43);
        chk("s4_crc_a_bpc8", r8, 32'hE8B7BE43);

        // 3: overflow with back-to-back pushes
        wr(ADDR_CTRL, 8'h0F);
        push_burst(5);
        chk("s3_no_ovf_after_5", {31'b0, uo_out[1]}, 32'h0);
        rd(ADDR_STAT, d, d16, d8);
        chk("s3_stat_full", {24'b0, d}, 32'h000000A4);
        wr(ADDR_DATA, 8'h77);
        rd(ADDR_STAT, d, d16, d8);
        chk("s3_stat_ovf", {24'b0, d}, 32'h000000E4);
        chk("s3_uo_ovf", {31'b0, uo_out[1]}, 32'h1);
        chk("s3_uo_ovf_bpc8", {31'b0, uo_out8[1]}, 32'h0);
        wr(ADDR_STAT, 8'h40);
        chk("s3_ovf_cleared", {31'b0, uo_out[1]}, 32'h0);
        wait_idle("s3_drain");

        // 5: clear mid-byte with three bytes queued
        wr(ADDR_CTRL, 8'h0F);
        push_burst(4);
        rd(ADDR_STAT, d, d16, d8);
        chk("s5_stat_queued", {24'b0, d}, 32'h00000083);
        wr(ADDR_CTRL, 8'h0F);
        chk("s5_busy_after_clear", {31'b0, uo_out[0]}, 32'h0);
        chk("s5_busy8_after_clear", {31'b0, uo_out8[0]}, 32'h0);
        rd(ADDR_STAT, d, d16, d8);
        chk("s5_stat_after_clear", {24'b0, d}, 32'h00000010);
        rd_res(r, r16, r8);
        chk("s5_result", r, 32'h0);
        chk("s5_result_bpc8", r8, 32'h0);

        // 6: reset mid-SHIFT after disturbing configuration
        wr(ADDR_CTRL, 8'h00);
        wr(4'h6, 8'h12);
        wr(ADDR_DATA, 8'h5A);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_uo_in_reset", {24'b0, uo_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_reset_table("s6");
        scenario_crc32("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
